// File: rtl/ssm_fp16_pkg.sv
// rtl/ssm_fp16_pkg.sv - FP16 constants, FSM state type and binary16 mul/add helpers
package ssm_fp16_pkg;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam int          FP16_BIAS = 15;

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_e;

    function automatic logic fp16_is_nan(input logic [15:0] a);
        return (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
    endfunction

    function automatic logic fp16_is_inf(input logic [15:0] a);
        return (a[14:10] == 5'h1F) && (a[9:0] == 10'h000);
    endfunction

    // Round-to-nearest-even on an 11-bit significand (hidden bit at [10]),
    // then saturate to Inf or flush to signed zero.
    function automatic logic [15:0] fp16_pack(input logic s, input int e,
                                              input logic [10:0] m11,
                                              input logic g, input logic st);
        logic [11:0] r;
        int          ee;
        r  = {1'b0, m11} + {11'b0, (g & (st | m11[0]))};
        ee = e;
        if (r[11]) begin
            ee = ee + 1;
            r  = r >> 1;
        end
        if (ee >= 31) return {s, 5'h1F, 10'h000};
        if (ee <= 0)  return {s, 15'h0000};
        return {s, ee[4:0], r[9:0]};
    endfunction

    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [21:0] prod;
        int          e;
        s = a[15] ^ b[15];
        if (fp16_is_nan(a) || fp16_is_nan(b)) return FP16_QNAN;
        if (fp16_is_inf(a)) return (b[14:10] == 5'h00) ? FP16_QNAN : {s, 5'h1F, 10'h000};
        if (fp16_is_inf(b)) return (a[14:10] == 5'h00) ? FP16_QNAN : {s, 5'h1F, 10'h000};
        // zero exponent covers true zeros and subnormals, both flushed
        if (a[14:10] == 5'h00 || b[14:10] == 5'h00) return {s, 15'h0000};
        prod = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
        e    = int'(a[14:10]) + int'(b[14:10]) - FP16_BIAS;
        if (prod[21]) return fp16_pack(s, e + 1, prod[21:11], prod[10], |prod[9:0]);
        return fp16_pack(s, e, prod[20:10], prod[9], |prod[8:0]);
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [13:0] big;
        logic [13:0] sm;
        logic [14:0] sum;
        logic        sticky;
        int          d;
        int          e;
        if (fp16_is_nan(a) || fp16_is_nan(b)) return FP16_QNAN;
        if (fp16_is_inf(a) && fp16_is_inf(b)) return (a[15] != b[15]) ? FP16_QNAN : a;
        if (fp16_is_inf(a)) return a;
        if (fp16_is_inf(b)) return b;
        if (a[14:10] == 5'h00 && b[14:10] == 5'h00) return {a[15] & b[15], 15'h0000};
        if (a[14:10] == 5'h00) return b;
        if (b[14:10] == 5'h00) return a;
        // order by magnitude so the result takes the sign of the larger operand
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d      = int'(x[14:10]) - int'(y[14:10]);
        big    = {1'b1, x[9:0], 3'b000};
        sticky = 1'b0;
        sm     = {1'b1, y[9:0], 3'b000};
        if (d > 13) begin
            sm = 14'd1;
        end else begin
            for (int i = 0; i < 14; i++) begin
                if (i < d && sm[i]) sticky = 1'b1;
            end
            sm = (sm >> d) | {13'b0, sticky};
        end
        e = int'(x[14:10]);
        if (x[15] == y[15]) begin
            sum = {1'b0, big} + {1'b0, sm};
            if (sum[14]) begin
                sum = {1'b0, sum[14:1]} | {14'b0, sum[0]};
                e   = e + 1;
            end
        end else begin
            sum = {1'b0, big} - {1'b0, sm};
            if (sum == 15'd0) return FP16_ZERO;
            for (int i = 0; i < 14; i++) begin
                if (!sum[13]) begin
                    sum = sum << 1;
                    e   = e - 1;
                end
            end
        end
        return fp16_pack(x[15], e, sum[13:3], sum[2], |sum[1:0]);
    endfunction

endpackage

// File: rtl/ssm_lane.sv
// rtl/ssm_lane.sv - one (h,p) lane: SSM state update, C-weighted accumulate, D skip term
module ssm_lane
    import ssm_fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] dt_i,
    input  logic [15:0] da_i,
    input  logic [15:0] b_i,
    input  logic [15:0] c_i,
    input  logic [15:0] x_i,
    input  logic [15:0] h_prev_i,
    input  logic [15:0] d_i,
    output logic [15:0] y_o
);

    logic [15:0] acc_q, acc_d;
    logic [15:0] t1, t2, t3, hn, t4, t5;

    // Per-n datapath in fixed operation order, plus the final D*x skip add.
    always_comb begin
        t1  = fp16_mul(dt_i, b_i);
        t2  = fp16_mul(t1, x_i);
        t3  = fp16_mul(h_prev_i, da_i);
        hn  = fp16_add(t3, t2);
        t4  = fp16_mul(hn, c_i);
        t5  = fp16_mul(d_i, x_i);
        y_o = fp16_add(acc_q, t5);
        acc_d = acc_q;
        if (clr_i) acc_d = FP16_ZERO;
        else if (en_i) acc_d = fp16_add(acc_q, t4);
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= FP16_ZERO;
        else      acc_q <= acc_d;
    end

endmodule

// File: rtl/packing.sv
// rtl/packing.sv - tiled FP16 Mamba-2 SSM step: FSM, tile/n counters, operand muxes, y register
module packing
    import ssm_fp16_pkg::*;
#(
    parameter int B      = 1,
    parameter int H      = 24,
    parameter int P      = 64,
    parameter int N      = 128,
    parameter int H_tile = 3,
    parameter int P_tile = 2,
    parameter int DW     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic [B*H*DW-1:0]     dt_flat_in,
    input  logic [B*H*DW-1:0]     dA_flat_in,
    input  logic [B*N*DW-1:0]     Bmat_flat_in,
    input  logic [B*N*DW-1:0]     C_flat_in,
    input  logic [H*DW-1:0]       D_flat_in,
    input  logic [B*H*P*DW-1:0]   x_flat_in,
    input  logic [B*H*P*N*DW-1:0] h_prev_flat_in,
    output logic [B*H*P*DW-1:0]   y_flat_out
);

    localparam int HT  = H / H_tile;
    localparam int PT  = P / P_tile;
    localparam int L   = H_tile * P_tile;
    localparam int BCW = (B  > 1) ? $clog2(B)  : 1;
    localparam int HCW = (HT > 1) ? $clog2(HT) : 1;
    localparam int PCW = (PT > 1) ? $clog2(PT) : 1;
    localparam int NCW = (N  > 1) ? $clog2(N)  : 1;

    localparam logic [BCW-1:0] B_LAST  = BCW'(B - 1);
    localparam logic [HCW-1:0] HT_LAST = HCW'(HT - 1);
    localparam logic [PCW-1:0] PT_LAST = PCW'(PT - 1);
    localparam logic [NCW-1:0] N_LAST  = NCW'(N - 1);

    state_e             state_q, state_d;
    logic [BCW-1:0]     b_q, b_d;
    logic [HCW-1:0]     ht_q, ht_d;
    logic [PCW-1:0]     pt_q, pt_d;
    logic [NCW-1:0]     n_q, n_d;
    logic               done_q, done_d;
    logic [B*H*P*DW-1:0] y_q, y_d;

    logic [DW-1:0]      sel_dt [L];
    logic [DW-1:0]      sel_da [L];
    logic [DW-1:0]      sel_b  [L];
    logic [DW-1:0]      sel_c  [L];
    logic [DW-1:0]      sel_x  [L];
    logic [DW-1:0]      sel_hp [L];
    logic [DW-1:0]      sel_d  [L];
    logic [L*DW-1:0]    lane_y;
    logic               last_tile;

    assign last_tile  = (b_q == B_LAST) && (ht_q == HT_LAST) && (pt_q == PT_LAST);
    assign done       = done_q;
    assign y_flat_out = y_q;

    // Next-state: n walks 0..N-1 in RUN, FIN closes a tile and steps pt, then ht, then b.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        ht_d    = ht_q;
        pt_d    = pt_q;
        n_d     = n_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                done_d = (state_q == DONE) && !start;
                if (start) begin
                    state_d = RUN;
                    b_d     = '0;
                    ht_d    = '0;
                    pt_d    = '0;
                    n_d     = '0;
                end
            end
            RUN: begin
                if (n_q == N_LAST) state_d = FIN;
                else               n_d = n_q + 1'b1;
            end
            FIN: begin
                n_d = '0;
                if (last_tile) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                    if (pt_q != PT_LAST) begin
                        pt_d = pt_q + 1'b1;
                    end else begin
                        pt_d = '0;
                        if (ht_q != HT_LAST) begin
                            ht_d = ht_q + 1'b1;
                        end else begin
                            ht_d = '0;
                            b_d  = b_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand selection: lane (i,j) works on h = ht*H_tile+i, p = pt*P_tile+j at the current n.
    always_comb begin
        int bh;
        int bhp;
        int bn;
        int l;
        bh  = 0;
        bhp = 0;
        bn  = int'(b_q) * N + int'(n_q);
        l   = 0;
        for (int i = 0; i < H_tile; i++) begin
            for (int j = 0; j < P_tile; j++) begin
                l   = i * P_tile + j;
                bh  = int'(b_q) * H + int'(ht_q) * H_tile + i;
                bhp = bh * P + int'(pt_q) * P_tile + j;
                sel_dt[l] = dt_flat_in[DW*bh +: DW];
                sel_da[l] = dA_flat_in[DW*bh +: DW];
                sel_b[l]  = Bmat_flat_in[DW*bn +: DW];
                sel_c[l]  = C_flat_in[DW*bn +: DW];
                sel_x[l]  = x_flat_in[DW*bhp +: DW];
                sel_hp[l] = h_prev_flat_in[DW*(bhp*N + int'(n_q)) +: DW];
                sel_d[l]  = D_flat_in[DW*(int'(ht_q) * H_tile + i) +: DW];
            end
        end
    end

    for (genvar gl = 0; gl < L; gl++) begin : g_lane
        ssm_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (state_q != RUN),
            .en_i     (state_q == RUN),
            .dt_i     (sel_dt[gl]),
            .da_i     (sel_da[gl]),
            .b_i      (sel_b[gl]),
            .c_i      (sel_c[gl]),
            .x_i      (sel_x[gl]),
            .h_prev_i (sel_hp[gl]),
            .d_i      (sel_d[gl]),
            .y_o      (lane_y[gl*DW +: DW])
        );
    end

    // y write-back of the current tile's lanes in FIN; untouched elements hold.
    always_comb begin
        int pos;
        pos = 0;
        y_d = y_q;
        if (state_q == FIN) begin
            for (int i = 0; i < H_tile; i++) begin
                for (int j = 0; j < P_tile; j++) begin
                    pos = (int'(b_q) * H + int'(ht_q) * H_tile + i) * P + int'(pt_q) * P_tile + j;
                    y_d[DW*pos +: DW] = lane_y[(i*P_tile + j)*DW +: DW];
                end
            end
        end
    end

    // State, counters, done flag and y register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            ht_q    <= '0;
            pt_q    <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            ht_q    <= ht_d;
            pt_q    <= pt_d;
            n_q     <= n_d;
            done_q  <= done_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: tb/tb_packing.sv
// tb/tb_packing.sv - scoreboard bench for packing with B=1 H=2 P=2 N=4 H_tile=1 P_tile=2
module tb_packing;

    localparam int NH  = 2;
    localparam int NP  = 2;
    localparam int NN  = 4;
    localparam int LAT = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic done;

    logic [15:0] dt_a [NH];
    logic [15:0] da_a [NH];
    logic [15:0] d_a  [NH];
    logic [15:0] bm_a [NN];
    logic [15:0] c_a  [NN];
    logic [15:0] x_a  [NH*NP];
    logic [15:0] hp_a [NH*NP*NN];

    logic [NH*16-1:0]       dt_flat, da_flat, d_flat;
    logic [NN*16-1:0]       bm_flat, c_flat;
    logic [NH*NP*16-1:0]    x_flat, y_flat;
    logic [NH*NP*NN*16-1:0] hp_flat;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NH; i++) begin
            dt_flat[16*i +: 16] = dt_a[i];
            da_flat[16*i +: 16] = da_a[i];
            d_flat[16*i +: 16]  = d_a[i];
        end
        for (int i = 0; i < NN; i++) begin
            bm_flat[16*i +: 16] = bm_a[i];
            c_flat[16*i +: 16]  = c_a[i];
        end
        for (int i = 0; i < NH*NP; i++) x_flat[16*i +: 16] = x_a[i];
        for (int i = 0; i < NH*NP*NN; i++) hp_flat[16*i +: 16] = hp_a[i];
    end

    packing #(.B(1), .H(NH), .P(NP), .N(NN), .H_tile(1), .P_tile(2), .DW(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .done           (done),
        .dt_flat_in     (dt_flat),
        .dA_flat_in     (da_flat),
        .Bmat_flat_in   (bm_flat),
        .C_flat_in      (c_flat),
        .D_flat_in      (d_flat),
        .x_flat_in      (x_flat),
        .h_prev_flat_in (hp_flat),
        .y_flat_out     (y_flat)
    );

    typedef struct {
        logic [63:0] y;
        int          t0;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: on each rising done, pop the oldest expectation and compare y and latency.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                for (int k = 0; k < NH*NP; k++) begin
                    checks++;
                    if (y_flat[16*k +: 16] !== mon_e.y[16*k +: 16]) begin
                        errors++;
                        $display("FAIL y[%0d] got %h expected %h", k, y_flat[16*k +: 16], mon_e.y[16*k +: 16]);
                    end
                end
                checks++;
                if (cyc - mon_e.t0 != LAT) begin
                    errors++;
                    $display("FAIL latency got %0d expected %0d", cyc - mon_e.t0, LAT);
                end
            end
        end
        done_prev = done;
    end

    task automatic set_all(input logic [15:0] dt, input logic [15:0] da, input logic [15:0] bm,
                           input logic [15:0] c, input logic [15:0] d, input logic [15:0] x,
                           input logic [15:0] hp);
        for (int i = 0; i < NH; i++) begin
            dt_a[i] = dt;
            da_a[i] = da;
            d_a[i]  = d;
        end
        for (int i = 0; i < NN; i++) begin
            bm_a[i] = bm;
            c_a[i]  = c;
        end
        for (int i = 0; i < NH*NP; i++) x_a[i] = x;
        for (int i = 0; i < NH*NP*NN; i++) hp_a[i] = hp;
    endtask

    // One run: push the expectation, optionally re-pulse start mid-run, wait bounded for done.
    task automatic run(input logic [63:0] ey, input int pulse_at);
        int k;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back('{y: ey, t0: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            start = (k == pulse_at);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done got 0 expected 1");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold got %b expected 1", done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        set_all(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++;
        if (y_flat !== 64'h0) begin errors++; $display("FAIL reset_y got %h expected 0", y_flat); end
        @(negedge clk);
        rst = 1'b1;

        run(64'h0000_0000_0000_0000, -1);

        set_all(16'h3C00, 16'h0000, 16'h3C00, 16'h3C00, 16'h0000, 16'h3C00, 16'h0000);
        run(64'h4400_4400_4400_4400, -1);

        set_all(16'h0000, 16'h3800, 16'h0000, 16'h3C00, 16'h0000, 16'h3C00, 16'h3C00);
        run(64'h4000_4000_4000_4000, -1);

        set_all(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h3C00, 16'h0000);
        run(64'h4000_4000_4000_4000, -1);
        x_a[2] = 16'hBC00;
        run(64'h4000_C000_4000_4000, -1);

        run(64'h4000_C000_4000_4000, 3);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b expected 0", done); end
        checks++;
        if (y_flat !== 64'h0) begin errors++; $display("FAIL abort_y got %h expected 0", y_flat); end
        @(negedge clk);
        rst = 1'b1;
        run(64'h4000_C000_4000_4000, -1);

        set_all(16'h7BFF, 16'h0000, 16'h7BFF, 16'h3C00, 16'h0000, 16'h3C00, 16'h0000);
        run(64'h7C00_7C00_7C00_7C00, -1);
        for (int i = 0; i < NH; i++) da_a[i] = 16'h3C00;
        hp_a[0] = 16'h7E00;
        run(64'h7C00_7C00_7C00_7E00, -1);

        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
